// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW/buffer-wait stall generator built on a
// shift register of in-flight destination tags, one slot per stage between
// ID and register-file write.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  ID_valid,
   input  logic [REG_ADDR_W-1:0] ID_rs,
   input  logic [REG_ADDR_W-1:0] ID_rt,
   input  logic                  ID_use_rs,
   input  logic                  ID_use_rt,
   input  logic                  ID_RegWrite,
   input  logic [REG_ADDR_W-1:0] ID_WriteRegister,
   input  logic                  ID_all_buff,
   input  logic                  all_buf_flags,
   input  logic                  flush,
   input  logic                  stat_clear,
   output logic                  ID_stall,
   output logic [1:0]            stall_reason,
   output logic [PIPE_DEPTH-1:0] inflight_mask,
   output logic [CNT_W-1:0]      stall_count
);

   logic [PIPE_DEPTH-1:0] slot_v;
   logic [REG_ADDR_W-1:0] slot_tag [PIPE_DEPTH];

   logic hit_rs;
   logic hit_rt;
   logic live;
   logic raw_rs;
   logic raw_rt;
   logic buf_wait;
   logic enqueue;

   // Look up both source registers against every in-flight destination tag;
   // register 0 is never a hazard.
   always_comb begin
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         if (slot_v[i] && (slot_tag[i] == ID_rs)) hit_rs = 1'b1;
         if (slot_v[i] && (slot_tag[i] == ID_rt)) hit_rt = 1'b1;
      end
      if (ID_rs == '0) hit_rs = 1'b0;
      if (ID_rt == '0) hit_rt = 1'b0;
   end

   // Qualify the hazards with a live, unflushed ID instruction and encode the
   // stall with rs > rt > buffer-wait priority.
   always_comb begin
      live         = ID_valid & ~flush & ~Rst;
      raw_rs       = live & ID_use_rs & hit_rs;
      raw_rt       = live & ID_use_rt & hit_rt;
      buf_wait     = live & ID_all_buff & ~all_buf_flags;
      ID_stall     = raw_rs | raw_rt | buf_wait;
      stall_reason = 2'd0;
      if (raw_rs) begin
         stall_reason = 2'd1;
      end else if (raw_rt) begin
         stall_reason = 2'd2;
      end else if (buf_wait) begin
         stall_reason = 2'd3;
      end
      enqueue = ID_valid & ~flush & ~ID_stall & ID_RegWrite &
                (ID_WriteRegister != '0);
   end

   // Advance the tag pipeline every cycle; a stalled or flushed ID pushes a
   // bubble, and the oldest slot drops off as its write completes.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         slot_v <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) slot_tag[i] <= '0;
      end else begin
         for (int i = PIPE_DEPTH - 1; i >= 1; i--) begin
            slot_v[i]   <= slot_v[i-1];
            slot_tag[i] <= slot_tag[i-1];
         end
         slot_v[0]   <= enqueue;
         slot_tag[0] <= ID_WriteRegister;
      end
   end

   // Saturating stalled-cycle counter; a clear wins over a simultaneous stall.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         stall_count <= '0;
      end else if (stat_clear) begin
         stall_count <= '0;
      end else if (ID_stall && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   assign inflight_mask = slot_v;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: drives three scoreboards of depth 3, 1 and 5 (the
// depth-1 one with a 4-bit counter) from one stimulus stream and compares
// every output against a per-register last-write-time model.
module tb_hazard_scoreboard;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       ID_valid;
   logic [4:0] ID_rs;
   logic [4:0] ID_rt;
   logic       ID_use_rs;
   logic       ID_use_rt;
   logic       ID_RegWrite;
   logic [4:0] ID_WriteRegister;
   logic       ID_all_buff;
   logic       all_buf_flags;
   logic       flush;
   logic       stat_clear;

   logic        stallA, stallB, stallC;
   logic [1:0]  reasonA, reasonB, reasonC;
   logic [2:0]  maskA;
   logic [0:0]  maskB;
   logic [4:0]  maskC;
   logic [15:0] cntA;
   logic [3:0]  cntB;
   logic [15:0] cntC;

   logic        stallW  [3];
   logic [1:0]  reasonW [3];
   logic [7:0]  maskW   [3];
   logic [15:0] cntW    [3];

   int checks   = 0;
   int failures = 0;

   int depthOf [3] = '{3, 1, 5};
   int cntMax  [3] = '{65535, 15, 65535};
   int lastWr  [3][32];
   bit enqHist [3][16];
   int cnt     [3];
   int edgeNo  = 0;

   always #5 Clk = ~Clk;

   hazard_scoreboard #(.REG_ADDR_W(5), .PIPE_DEPTH(3), .CNT_W(16)) dutA (
      .Clk(Clk), .Rst(Rst), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_RegWrite(ID_RegWrite),
      .ID_WriteRegister(ID_WriteRegister), .ID_all_buff(ID_all_buff),
      .all_buf_flags(all_buf_flags), .flush(flush), .stat_clear(stat_clear),
      .ID_stall(stallA), .stall_reason(reasonA), .inflight_mask(maskA),
      .stall_count(cntA));

   hazard_scoreboard #(.REG_ADDR_W(5), .PIPE_DEPTH(1), .CNT_W(4)) dutB (
      .Clk(Clk), .Rst(Rst), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_RegWrite(ID_RegWrite),
      .ID_WriteRegister(ID_WriteRegister), .ID_all_buff(ID_all_buff),
      .all_buf_flags(all_buf_flags), .flush(flush), .stat_clear(stat_clear),
      .ID_stall(stallB), .stall_reason(reasonB), .inflight_mask(maskB),
      .stall_count(cntB));

   hazard_scoreboard #(.REG_ADDR_W(5), .PIPE_DEPTH(5), .CNT_W(16)) dutC (
      .Clk(Clk), .Rst(Rst), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_RegWrite(ID_RegWrite),
      .ID_WriteRegister(ID_WriteRegister), .ID_all_buff(ID_all_buff),
      .all_buf_flags(all_buf_flags), .flush(flush), .stat_clear(stat_clear),
      .ID_stall(stallC), .stall_reason(reasonC), .inflight_mask(maskC),
      .stall_count(cntC));

   assign stallW[0]  = stallA;
   assign stallW[1]  = stallB;
   assign stallW[2]  = stallC;
   assign reasonW[0] = reasonA;
   assign reasonW[1] = reasonB;
   assign reasonW[2] = reasonC;
   assign maskW[0]   = {5'd0, maskA};
   assign maskW[1]   = {7'd0, maskB};
   assign maskW[2]   = {3'd0, maskC};
   assign cntW[0]    = cntA;
   assign cntW[1]    = {12'd0, cntB};
   assign cntW[2]    = cntC;

   // A register is busy while fewer than depth+1 edges have passed since the
   // most recent unstalled instruction that wrote it left ID.
   function automatic bit busyModel(int k, logic [4:0] r);
      int age;
      age = edgeNo - lastWr[k][r];
      return (r != 5'd0) && (age >= 1) && (age <= depthOf[k]);
   endfunction

   function automatic logic [1:0] expReason(int k);
      bit live;
      live = ID_valid && !flush && !Rst;
      if (live && ID_use_rs && busyModel(k, ID_rs)) return 2'd1;
      if (live && ID_use_rt && busyModel(k, ID_rt)) return 2'd2;
      if (live && ID_all_buff && !all_buf_flags)    return 2'd3;
      return 2'd0;
   endfunction

   // Slot i currently holds whatever left ID i+1 edges ago.
   function automatic logic [7:0] expMask(int k);
      logic [7:0] m;
      m = 8'd0;
      for (int i = 0; i < depthOf[k]; i++) m[i] = enqHist[k][(edgeNo - 1 - i) & 15];
      return m;
   endfunction

   task automatic modelClear();
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < 32; r++) lastWr[k][r] = -1000;
         for (int h = 0; h < 16; h++) enqHist[k][h] = 1'b0;
         cnt[k] = 0;
      end
   endtask

   task automatic modelEdge();
      bit s;
      bit en;
      for (int k = 0; k < 3; k++) begin
         if (Rst) begin
            for (int r = 0; r < 32; r++) lastWr[k][r] = -1000;
            for (int h = 0; h < 16; h++) enqHist[k][h] = 1'b0;
            cnt[k] = 0;
         end else begin
            s  = (expReason(k) != 2'd0);
            en = ID_valid && !flush && !s && ID_RegWrite && (ID_WriteRegister != 5'd0);
            enqHist[k][edgeNo & 15] = en;
            if (en) lastWr[k][ID_WriteRegister] = edgeNo;
            if (stat_clear) cnt[k] = 0;
            else if (s && cnt[k] < cntMax[k]) cnt[k] = cnt[k] + 1;
         end
      end
      edgeNo++;
   endtask

   task automatic applyStimulus(input logic rst, input logic valid,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic useRs, input logic useRt,
                                input logic regWrite, input logic [4:0] wr,
                                input logic allBuff, input logic flags,
                                input logic fl, input logic clr);
      Rst              = rst;
      ID_valid         = valid;
      ID_rs            = rs;
      ID_rt            = rt;
      ID_use_rs        = useRs;
      ID_use_rt        = useRt;
      ID_RegWrite      = regWrite;
      ID_WriteRegister = wr;
      ID_all_buff      = allBuff;
      all_buf_flags    = flags;
      flush            = fl;
      stat_clear       = clr;
   endtask

   task automatic checkOutput();
      logic [1:0]  r;
      logic [7:0]  m;
      logic [15:0] c;
      for (int k = 0; k < 3; k++) begin
         r = expReason(k);
         m = expMask(k);
         c = 16'(cnt[k]);
         checks++;
         assert (stallW[k] === (r != 2'd0)) else begin
            failures++;
            $error("[TB] FAIL stall[%0d] t=%0t observed=%b expected=%b", k, $time, stallW[k], (r != 2'd0));
         end
         checks++;
         assert (reasonW[k] === r) else begin
            failures++;
            $error("[TB] FAIL reason[%0d] t=%0t observed=%0d expected=%0d", k, $time, reasonW[k], r);
         end
         checks++;
         assert (maskW[k] === m) else begin
            failures++;
            $error("[TB] FAIL mask[%0d] t=%0t observed=%b expected=%b", k, $time, maskW[k], m);
         end
         checks++;
         assert (cntW[k] === c) else begin
            failures++;
            $error("[TB] FAIL count[%0d] t=%0t observed=%0d expected=%0d", k, $time, cntW[k], c);
         end
      end
   endtask

   task automatic checkConst(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic doCycle();
      #2;
      checkOutput();
      modelEdge();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
         doCycle();
      end
   endtask

   task automatic doReset();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
         doCycle();
      end
   endtask

   // Producer of r5, `gap` independent instructions, then a consumer of r5
   // held in ID long enough for the deepest scoreboard to release it.
   task automatic rawScenario(input int gap);
      doReset();
      idle(1);
      applyStimulus(0, 1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 1, 0, 0);
      doCycle();
      for (int i = 0; i < gap; i++) begin
         applyStimulus(0, 1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0, 1, 0, 0);
         doCycle();
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 0, 1, 0, 0);
         doCycle();
      end
      idle(2);
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      @(posedge Clk);
      #1;
      @(posedge Clk);
      #1;
      modelClear();

      $display("[TB] reset and idle");
      doReset();
      idle(3);
      checkConst("reset_count_A", cntA, 16'd0);

      $display("[TB] back-to-back RAW");
      rawScenario(0);
      checkConst("raw_b2b_A", cntA, 16'd3);
      checkConst("raw_b2b_B", {12'd0, cntB}, 16'd1);
      checkConst("raw_b2b_C", cntC, 16'd5);

      $display("[TB] RAW with two independent instructions between");
      rawScenario(2);
      checkConst("raw_gap2_A", cntA, 16'd1);
      checkConst("raw_gap2_B", {12'd0, cntB}, 16'd0);
      checkConst("raw_gap2_C", cntC, 16'd3);

      $display("[TB] rt-only consumer and r0 producer");
      doReset();
      applyStimulus(0, 1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 1, 0, 0);
      doCycle();
      applyStimulus(0, 1, 5'd5, 5'd1, 0, 1, 1, 5'd6, 0, 1, 0, 0);
      doCycle();
      applyStimulus(0, 1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0, 1, 0, 0);
      doCycle();
      applyStimulus(0, 1, 5'd0, 5'd0, 1, 1, 1, 5'd8, 0, 1, 0, 0);
      doCycle();
      idle(1);
      checkConst("no_stall_C", cntC, 16'd0);

      $display("[TB] buffer wait");
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1, 0, 0, 0);
         doCycle();
      end
      applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1, 1, 0, 0);
      doCycle();
      idle(1);
      checkConst("bufwait_A", cntA, 16'd5);

      $display("[TB] flush and mid-stall reset");
      doReset();
      applyStimulus(0, 1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 1, 0, 0);
      doCycle();
      applyStimulus(0, 1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 0, 1, 1, 0);
      doCycle();
      applyStimulus(0, 1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 0, 1, 0, 0);
      doCycle();
      applyStimulus(1, 1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 0, 1, 0, 0);
      doCycle();
      applyStimulus(0, 1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 0, 1, 0, 0);
      doCycle();
      idle(2);

      $display("[TB] counter saturation and clear");
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
         doCycle();
      end
      checkConst("sat_B", {12'd0, cntB}, 16'd15);
      checkConst("sat_A", cntA, 16'd20);
      applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 1);
      doCycle();
      checkConst("clear_A", cntA, 16'd0);
      checkConst("clear_B", {12'd0, cntB}, 16'd0);

      $display("[TB] random traffic");
      doReset();
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 49) == 0,
                       $urandom_range(0, 3) != 0,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       1'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom_range(0, 7)),
                       $urandom_range(0, 7) == 0, 1'($urandom),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
         doCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the decode-stage hazard detector. It replaces fixed per-stage destination comparators with a PIPE_DEPTH-deep shift register of in-flight destination tags. It adds per-operand use qualification, flush-aware enqueue, a buffer-ready wait, a stall-reason code and a saturating stall-cycle counter. It sits beside the decoder in ID and drives the front-end stall that freezes PC and IF/ID.

## Interface
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero and never tracked.
- PIPE_DEPTH, 3, number of stages between ID and register-file write (EX, MEM, SAD); legal range 1–8.
- CNT_W, 16, stall counter width.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- ID_valid  in  1  ID holds a live instruction.
- ID_rs, ID_rt  in  REG_ADDR_W  source register fields.
- ID_use_rs, ID_use_rt  in  1  instruction actually reads rs / rt (from the decoder).
- ID_RegWrite  in  1  instruction writes a register.
- ID_WriteRegister  in  REG_ADDR_W  destination register (already muxed rd/rt/31).
- ID_all_buff  in  1  instruction must wait for buffer-ready flags.
- all_buf_flags  in  1  SAD buffers loaded.
- flush  in  1  ID instruction is squashed this cycle.
- stat_clear  in  1  zero the stall counter.
- ID_stall  out  1  hold PC and IF/ID, inject a bubble into EX.
- stall_reason  out  2  0 none, 1 RAW on rs, 2 RAW on rt, 3 buffer wait.
- inflight_mask  out  PIPE_DEPTH  valid bit of each scoreboard slot; bit 0 = EX.
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- State consists of two parts:
  - Slots slot[0..PIPE_DEPTH-1], each holding {v, tag}.
  - stall_count.
- Per-cycle slot update, when Rst is low:
  - slot[i] <= slot[i-1] for i ≥ 1. Slot[PIPE_DEPTH-1] is discarded, because its write completes that cycle.
  - slot[0].v <= ID_valid & ~flush & ~ID_stall & ID_RegWrite & (ID_WriteRegister != 0).
  - slot[0].tag <= ID_WriteRegister.
- A stalled or flushed ID inserts a bubble (v=0). Slots always advance; there is no back-pressure from later stages.
- hit(r) = (r != 0) & OR over i of (slot[i].v & slot[i].tag == r).
- Stall conditions, all gated by ID_valid & ~flush & ~Rst:
  - raw_rs = ID_use_rs & hit(ID_rs)
  - raw_rt = ID_use_rt & hit(ID_rt)
  - bw = ID_all_buff & ~all_buf_flags
- ID_stall = raw_rs | raw_rt | bw. The output is combinational and never registered.
- stall_reason priority: rs > rt > buffer wait. When ID_stall=0, stall_reason=0.
- stall_count:
  - stat_clear has priority and sets it to 0.
  - Otherwise it increments when ID_stall=1 and holds at all-ones.
- inflight_mask[i] = slot[i].v.
- Multiple slots holding the same tag is legal; hit remains set until the youngest matching slot shifts out.

## Timing
- Reset: on any edge with Rst=1, all slots get v=0 and stall_count=0. While Rst=1, ID_stall=0 and stall_reason=0. inflight_mask reads 0 from the cycle after the reset edge. Asserting Rst mid-stall releases the stall in that same cycle.
- RAW latency: a producer leaving ID unstalled at edge t occupies slot[0] through slot[PIPE_DEPTH-1] during cycles t+1 … t+PIPE_DEPTH. A dependent instruction in ID stalls for exactly PIPE_DEPTH cycles when back-to-back, and for PIPE_DEPTH−k cycles with k independent instructions between them. The consumer proceeds in cycle t+PIPE_DEPTH+1.
- Buffer wait: ID_stall follows ~all_buf_flags in the same cycle. There is no timeout.
- flush and stall in the same cycle: flush wins. ID_stall=0 and nothing is enqueued.
- stat_clear together with a stall: the counter reads 0 after the edge.

## Test plan
- Rst for 2 cycles, then idle → inflight_mask=0, ID_stall=0, stall_count=0.
- PIPE_DEPTH=3: issue `add r5` followed immediately by `add r6,r5,r1` (use_rs) → ID_stall=1 for 3 cycles with stall_reason=1, then released. stall_count=3.
- The same pair with two independent instructions between them → 1 stall cycle. Consumer with use_rt only and ID_rs=5 → no stall. Producer writing r0 → never tracked, no stall.
- ID_all_buff=1, all_buf_flags low for 5 cycles → 5 stall cycles, stall_reason=3. The stall releases in the cycle the flag rises.
- Dependent instruction with flush=1 → ID_stall=0 and slot[0].v=0 on the next cycle. Rst asserted during a RAW stall → ID_stall drops immediately and all slots clear.
- CNT_W=4: hold a stall for 20 cycles → stall_count saturates at 15. stat_clear → 0.
- Repeat the RAW scenario with PIPE_DEPTH=1 and PIPE_DEPTH=5 → 1 and 5 stall cycles.
